// File: rtl/ysyx_23060077_axi_rd_arbiter.sv
// Shares one AXI4 read master between Icache refill (I) and LSU/Dcache (D); the grant is held until RLAST. AR issues 1 cycle after a request.
// R beats are forwarded combinationally and rready is high throughout DATA. Define YSYX_23060077_ARB_RR_EN for round-robin tie-break instead of D priority.
module ysyx_23060077_axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int ID_WIDTH   = 4,
    parameter int I_ID       = 0,
    parameter int D_ID       = 1
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  i_valid_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic [LEN_WIDTH-1:0]  i_len_i,
    output logic                  i_ready_o,
    output logic [DATA_WIDTH-1:0] i_data_o,
    output logic                  i_last_o,

    input  logic                  d_valid_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [LEN_WIDTH-1:0]  d_len_i,
    output logic                  d_ready_o,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic                  d_last_o,

    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [LEN_WIDTH-1:0]  arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic [ID_WIDTH-1:0]   arid_o,

    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic [ID_WIDTH-1:0]   rid_i,

    output logic                  resp_err_o,
    output logic                  len_err_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [ID_WIDTH-1:0]   id;
    } ar_req_t;

    localparam logic [LEN_WIDTH:0] CNT_ONE = (LEN_WIDTH+1)'(1);

    state_e             state_q;
    ar_req_t            ar_q;
    ar_req_t            ar_d;
    logic               arvalid_q;
    logic               grant_q;        // 1 = D owns the channel
    logic               last_grant_q;
    logic               resp_sticky_q;
    logic [LEN_WIDTH:0] beat_cnt_q;
    logic [LEN_WIDTH:0] beat_cnt_d;

    logic pick_d;
    logic r_hs;
    logic id_ok;
    logic beat_ok;
    logic burst_end;
    logic resp_bad;

`ifdef YSYX_23060077_ARB_RR_EN
    // On a tie the requester that did not finish the previous burst wins.
    assign pick_d = d_valid_i & (~i_valid_i | ~last_grant_q);
`else
    assign pick_d = d_valid_i;
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    always_comb begin
        ar_d = '0;
        if (pick_d) begin
            ar_d.addr = d_addr_i;
            ar_d.len  = d_len_i;
            ar_d.id   = ID_WIDTH'(D_ID);
        end else begin
            ar_d.addr = i_addr_i;
            ar_d.len  = i_len_i;
            ar_d.id   = ID_WIDTH'(I_ID);
        end
    end

    assign rready_o   = (state_q == DATA);
    assign r_hs       = rvalid_i & rready_o;
    assign id_ok      = (rid_i == ar_q.id);
    assign beat_ok    = r_hs & id_ok;
    assign burst_end  = beat_ok & rlast_i;
    // A stray-ID beat is drained so the slave cannot stall, but it poisons the burst status.
    assign resp_bad   = r_hs & ((rresp_i != 2'b00) | ~id_ok);
    assign beat_cnt_d = beat_cnt_q + CNT_ONE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ar_q          <= '0;
            arvalid_q     <= 1'b0;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b0;
            resp_sticky_q <= 1'b0;
            beat_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid_i | d_valid_i) begin
                        ar_q      <= ar_d;
                        grant_q   <= pick_d;
                        arvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (arvalid_q & arready_i) begin
                        arvalid_q     <= 1'b0;
                        beat_cnt_q    <= '0;
                        resp_sticky_q <= 1'b0;
                        state_q       <= DATA;
                    end
                end
                DATA: begin
                    if (beat_ok) begin
                        beat_cnt_q <= beat_cnt_d;
                    end
                    if (resp_bad) begin
                        resp_sticky_q <= 1'b1;
                    end
                    if (burst_end) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign arvalid_o  = arvalid_q;
    assign araddr_o   = ar_q.addr;
    assign arlen_o    = ar_q.len;
    assign arid_o     = ar_q.id;
    assign arsize_o   = 3'b010;
    assign arburst_o  = 2'b01;

    assign i_ready_o  = beat_ok & ~grant_q;
    assign i_last_o   = i_ready_o & rlast_i;
    assign i_data_o   = grant_q ? '0 : rdata_i;
    assign d_ready_o  = beat_ok & grant_q;
    assign d_last_o   = d_ready_o & rlast_i;
    assign d_data_o   = grant_q ? rdata_i : '0;

    assign resp_err_o = burst_end & (resp_sticky_q | (rresp_i != 2'b00));
    assign len_err_o  = burst_end & (beat_cnt_d != ({1'b0, ar_q.len} + CNT_ONE));

endmodule

// File: tb/tb_ysyx_23060077_axi_rd_arbiter.sv
// Directed bench for the read arbiter: drives at +1 after posedge, samples at +4.
module tb_ysyx_23060077_axi_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_valid_i = 1'b0, d_valid_i = 1'b0;
    logic [31:0] i_addr_i = '0, d_addr_i = '0;
    logic [7:0]  i_len_i = '0, d_len_i = '0;
    logic        i_ready_o, i_last_o, d_ready_o, d_last_o;
    logic [31:0] i_data_o, d_data_o;
    logic        arvalid_o, arready_i = 1'b0;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic [3:0]  arid_o;
    logic        rvalid_i = 1'b0, rready_o;
    logic [31:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0;
    logic        rlast_i = 1'b0;
    logic [3:0]  rid_i = '0;
    logic        resp_err_o, len_err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    ysyx_23060077_axi_rd_arbiter dut (
        .clock(clock), .reset(reset),
        .i_valid_i(i_valid_i), .i_addr_i(i_addr_i), .i_len_i(i_len_i),
        .i_ready_o(i_ready_o), .i_data_o(i_data_o), .i_last_o(i_last_o),
        .d_valid_i(d_valid_i), .d_addr_i(d_addr_i), .d_len_i(d_len_i),
        .d_ready_o(d_ready_o), .d_data_o(d_data_o), .d_last_o(d_last_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o), .arid_o(arid_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i), .rid_i(rid_i),
        .resp_err_o(resp_err_o), .len_err_o(len_err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Entered at +1 of the cycle the AR phase is expected; leaves at +1 of the first DATA cycle.
    task automatic ar_phase(input string tag, input logic is_d, input logic [31:0] addr,
                            input logic [7:0] len, input int ar_wait);
        int waited = 0;
        #3;
        while (!arvalid_o && waited < 8) begin
            @(posedge clock);
            #4;
            waited++;
        end
        check({tag, "_ar_lat"}, 64'(waited), 64'd0);
        check({tag, "_araddr"}, 64'(araddr_o), 64'(addr));
        check({tag, "_arlen"}, 64'(arlen_o), 64'(len));
        check({tag, "_arid"}, 64'(arid_o), is_d ? 64'd1 : 64'd0);
        check({tag, "_arsize_burst"}, 64'({arsize_o, arburst_o}), 64'({3'b010, 2'b01}));
        for (int w = 0; w < ar_wait; w++) begin
            @(posedge clock);
            #4;
            check({tag, "_ar_hold"}, 64'({arvalid_o, araddr_o, arlen_o}), 64'({1'b1, addr, len}));
        end
        arready_i = 1'b1;
        step();
        arready_i = 1'b0;
    endtask

    task automatic beat(input string tag, input logic is_d, input logic [31:0] data,
                        input logic last, input logic [1:0] resp,
                        input logic exp_rerr, input logic exp_lerr);
        rvalid_i = 1'b1;
        rdata_i  = data;
        rlast_i  = last;
        rresp_i  = resp;
        rid_i    = is_d ? 4'd1 : 4'd0;
        if (last) begin
            if (is_d) d_valid_i = 1'b0;
            else      i_valid_i = 1'b0;
        end
        #3;
        check({tag, "_rdy"}, 64'(is_d ? d_ready_o : i_ready_o), 64'd1);
        check({tag, "_other_rdy"}, 64'(is_d ? i_ready_o : d_ready_o), 64'd0);
        check({tag, "_data"}, 64'(is_d ? d_data_o : i_data_o), 64'(data));
        check({tag, "_last"}, 64'(is_d ? d_last_o : i_last_o), 64'(last));
        check({tag, "_resp_err"}, 64'(resp_err_o), 64'(exp_rerr));
        check({tag, "_len_err"}, 64'(len_err_o), 64'(exp_lerr));
        step();
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        rresp_i  = 2'b00;
    endtask

    // Leaves at +4 of the first IDLE cycle after the burst.
    task automatic data_phase(input string tag, input logic is_d, input logic [7:0] len,
                              input int nbeats, input int bad_idx, input logic [31:0] base);
        logic lst;
        #3;
        check({tag, "_rready"}, 64'(rready_o), 64'd1);
        for (int k = 0; k < nbeats; k++) begin
            lst = (k == nbeats - 1);
            beat(tag, is_d, base + 32'(k), lst, (k == bad_idx) ? 2'b10 : 2'b00,
                 lst && (bad_idx >= 0), lst && (nbeats != int'(len) + 1));
        end
        #3;
        check({tag, "_idle"}, 64'({rready_o, arvalid_o}), 64'd0);
    endtask

    // Both requesters raise valid together; first_d says who must win.
    task automatic tie(input string tag, input logic first_d, input logic [31:0] base);
        i_valid_i = 1'b1; i_addr_i = 32'h100; i_len_i = 8'd0;
        d_valid_i = 1'b1; d_addr_i = 32'h200; d_len_i = 8'd0;
        step();
        ar_phase({tag, "_1st"}, first_d, first_d ? 32'h200 : 32'h100, 8'd0, 0);
        data_phase({tag, "_1st"}, first_d, 8'd0, 1, -1, base);
        step();
        ar_phase({tag, "_2nd"}, !first_d, first_d ? 32'h100 : 32'h200, 8'd0, 0);
        data_phase({tag, "_2nd"}, !first_d, 8'd0, 1, -1, base + 32'h10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tie2_first_d;
        #12;
        check("rst_outputs", 64'({arvalid_o, rready_o, i_ready_o, i_last_o, d_ready_o, d_last_o,
                                   resp_err_o, len_err_o}), 64'd0);
        check("rst_ar_regs", 64'({araddr_o, arlen_o, arid_o}), 64'd0);
        step();
        reset = 1'b1;

        // Single I burst, 4 beats.
        step();
        i_valid_i = 1'b1; i_addr_i = 32'h3000_0000; i_len_i = 8'd3;
        #3;
        check("t1_ar_before", 64'(arvalid_o), 64'd0);
        step();
        ar_phase("t1", 1'b0, 32'h3000_0000, 8'd3, 0);
        data_phase("t1", 1'b0, 8'd3, 4, -1, 32'hA0);

        // Tie after an I burst: D first in both arbitration modes.
        tie("tie1", 1'b1, 32'h50);

        // D burst with early rlast.
        d_valid_i = 1'b1; d_addr_i = 32'h300; d_len_i = 8'd3;
        step();
        ar_phase("lenerr", 1'b1, 32'h300, 8'd3, 0);
        data_phase("lenerr", 1'b1, 8'd3, 2, -1, 32'hB0);

`ifdef YSYX_23060077_ARB_RR_EN
        tie2_first_d = 1'b0;
`else
        tie2_first_d = 1'b1;
`endif
        tie("tie2", tie2_first_d, 32'h70);

        // I burst with a SLVERR on beat 2.
        i_valid_i = 1'b1; i_addr_i = 32'h400; i_len_i = 8'd3;
        step();
        ar_phase("resperr", 1'b0, 32'h400, 8'd3, 0);
        data_phase("resperr", 1'b0, 8'd3, 4, 1, 32'hC0);

        // D burst with AR stalled 5 cycles.
        d_valid_i = 1'b1; d_addr_i = 32'h500; d_len_i = 8'd1;
        step();
        ar_phase("stall", 1'b1, 32'h500, 8'd1, 5);
        data_phase("stall", 1'b1, 8'd1, 2, -1, 32'hD0);

        // Reset asserted during beat 2 of an I burst.
        i_valid_i = 1'b1; i_addr_i = 32'h5000; i_len_i = 8'd3;
        step();
        ar_phase("rst_mid", 1'b0, 32'h5000, 8'd3, 0);
        beat("rst_mid_b0", 1'b0, 32'hE0, 1'b0, 2'b00, 1'b0, 1'b0);
        rvalid_i = 1'b1; rdata_i = 32'hE1; rid_i = 4'd0;
        #2;
        check("rst_mid_pre", 64'(i_ready_o), 64'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_async", 64'({arvalid_o, rready_o, i_ready_o, i_last_o, d_ready_o}), 64'd0);
        i_valid_i = 1'b0;
        step();
        rvalid_i = 1'b0;
        reset = 1'b1;
        step();
        i_valid_i = 1'b1; i_addr_i = 32'h6000; i_len_i = 8'd1;
        #3;
        check("post_rst_ar_before", 64'(arvalid_o), 64'd0);
        step();
        ar_phase("post_rst", 1'b0, 32'h6000, 8'd1, 0);
        data_phase("post_rst", 1'b0, 8'd1, 2, -1, 32'hF0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_axi_rd_arbiter.md
Name: ysyx_23060077_axi_rd_arbiter

Overview:
- Shares the core's single AXI4 read master channel between two burst-read requesters: Icache refill (I) and the LSU/Dcache (D).
- Each requester uses the same valid/addr/len → ready/data/last handshake the Icache already drives.
- The block selects one requester, issues the AR beat, and steers R beats back to the granted requester.
- It holds the grant until RLAST, and checks burst length, response code and ID.

Parameters:
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data beat width.
- LEN_WIDTH, 8: AXI arlen width (beats - 1).
- ID_WIDTH, 4: AXI id width.
- I_ID, 0: arid used for I transactions.
- D_ID, 1: arid used for D transactions.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_valid_i  in  1  I request; held until its last beat.
- i_addr_i  in  ADDR_WIDTH  I start address.
- i_len_i  in  LEN_WIDTH  I beats - 1.
- i_ready_o  out  1  I data beat valid (one-cycle pulse per beat).
- i_data_o  out  DATA_WIDTH  I beat data.
- i_last_o  out  1  I final beat.
- d_valid_i, d_addr_i, d_len_i, d_ready_o, d_data_o, d_last_o: same as the I ports, for the D requester.
- arvalid_o  out  1  AXI AR valid.
- arready_i  in  1  AXI AR ready.
- araddr_o  out  ADDR_WIDTH  AR address.
- arlen_o  out  LEN_WIDTH  AR length.
- arsize_o  out  3  fixed 3'b010.
- arburst_o  out  2  fixed 2'b01 (INCR).
- arid_o  out  ID_WIDTH  I_ID or D_ID.
- rvalid_i  in  1  AXI R valid.
- rready_o  out  1  AXI R ready.
- rdata_i  in  DATA_WIDTH  R data.
- rresp_i  in  2  R response.
- rlast_i  in  1  R last.
- rid_i  in  ID_WIDTH  R id.
- resp_err_o  out  1  one-cycle pulse: burst finished with any non-OKAY rresp.
- len_err_o  out  1  one-cycle pulse: rlast arrived with beat count ≠ latched len+1.

Behaviour:
- Reset (reset==0), asynchronous:
  - state=IDLE; arvalid_o=0, rready_o=0.
  - All *_ready_o, *_last_o, resp_err_o, len_err_o = 0.
  - araddr_o, arlen_o, arid_o = 0; beat_cnt=0; last_grant=I.
  - Reset mid-burst abandons the burst immediately; outstanding beats are not tracked after release.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any *_valid_i is high, arbitrate and latch the winner's addr, len and id into the AR registers.
  - Set grant and go to ADDR. arvalid_o rises the cycle after the request is seen (1-cycle latency).
  - Arbitration: fixed priority D > I (see Optional Feature).
- ADDR:
  - arvalid_o=1, with araddr/arlen/arid stable until arvalid_o & arready_i.
  - On that handshake go to DATA and clear beat_cnt.
- DATA:
  - rready_o=1 (combinational, state==DATA).
  - Per beat, when rvalid_i & rready_o & (rid_i==latched id):
    - the granted *_ready_o=1 and *_data_o=rdata_i in the same cycle (combinational);
    - *_last_o=rlast_i;
    - beat_cnt increments.
  - A beat with mismatched rid_i is consumed but not forwarded, and sets a sticky resp flag.
  - The non-granted requester's ready/last stay 0; its data output is don't-care (drive 0).
  - On the accepted beat with rlast_i=1:
    - pulse len_err_o if beat_cnt+1 ≠ arlen+1;
    - pulse resp_err_o if any beat in the burst had rresp≠0 or an id mismatch;
    - update last_grant and return to IDLE.
  - A new arbitration can issue AR no earlier than 2 cycles after rlast (IDLE → ADDR).
- Grant lock: a requester dropping valid mid-burst does not abort the burst. Remaining beats are still accepted and the ready pulses still occur.
- Simultaneous requests in IDLE: exactly one grant. The loser's valid stays high and is granted in the next IDLE.
- No address or length translation. arlen_o = latched len. beat_cnt is LEN_WIDTH+1 bits and never wraps for len=255.

Optional Feature:
- Macro: YSYX_23060077_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests, the requester that was not last_grant wins. last_grant updates at each burst completion.
- Undefined: fixed priority. D always wins a tie; last_grant is still tracked but unused.

Test Plan:
- Reset then i_valid_i=1, addr=0x3000_0000, len=3; slave arready immediate, 4 R beats 0xA0..0xA3 with rlast on beat 4:
  - arvalid_o high 1 cycle after valid; araddr=0x3000_0000, arlen=3, arid=0;
  - i_ready_o pulses 4×, i_last_o on 0xA3; d_ready_o stays 0; no error pulses.
- i_valid_i and d_valid_i rise in the same cycle (addr 0x100/0x200, len 0), one beat each:
  - fixed priority: AR sequence 0x200 (id 1) then 0x100 (id 0);
  - with RR_EN after a prior I burst: same order; after a prior D burst: 0x100 first.
- len=3 but slave asserts rlast on beat 2 → d_last_o on beat 2, len_err_o pulses once, FSM returns to IDLE.
- Beat 2 of 4 has rresp=2'b10 → all 4 beats forwarded, resp_err_o pulses in the rlast cycle only.
- arready held 0 for 5 cycles → arvalid_o, araddr, arlen constant throughout; transfer completes normally once arready=1.
- reset driven low during DATA beat 2 → arvalid_o, rready_o, *_ready_o drop to 0 asynchronously. After release, a new I request is served from IDLE.
